univ_shift_reg: RTL

//  Parametrised universal register for data-path staging. Supports hold, parallel load,
//  and single-step shift/rotate in either direction. A counted burst mode shifts N places

---
 rtl/univ_shift_reg.sv | 111 +++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, single-step shift/rotate in either
// direction, and an autonomous counted burst of shifts with busy/done status.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] po,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_e             state_q;
    logic [WIDTH-1:0]   po_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_right_q;
    logic               rot_q;
    logic               busy_q;
    logic               done_q;

    // One shift step; rotate recirculates the bit shifted out, otherwise the serial input fills.
    function automatic logic [WIDTH-1:0] shift_once(
        input logic [WIDTH-1:0] v,
        input logic             right,
        input logic             rot,
        input logic             smsb,
        input logic             slsb
    );
        if (right) begin
            return {(rot ? v[0] : smsb), v[WIDTH-1:1]};
        end else begin
            return {v[WIDTH-2:0], (rot ? v[WIDTH-1] : slsb)};
        end
    endfunction

    // NOTE: every register in this block uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            po_q        <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            rot_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (mode == MODE_SHR || mode == MODE_SHL)) begin
                        if (nshift == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            dir_right_q <= (mode == MODE_SHR);
                            rot_q       <= rotate;
                            cnt_q       <= nshift;
                            busy_q      <= 1'b1;
                            state_q     <= SHIFT;
                        end
                    end else begin
                        case (mode)
                            MODE_HOLD: po_q <= po_q;
                            MODE_SHR:  po_q <= shift_once(po_q, 1'b1, rotate, sin_msb, sin_lsb);
                            MODE_SHL:  po_q <= shift_once(po_q, 1'b0, rotate, sin_msb, sin_lsb);
                            MODE_LOAD: po_q <= pi;
                            default:   po_q <= po_q;
                        endcase
                    end
                end
                SHIFT: begin
                    // Serial inputs are sampled live; direction and rotate were latched at start.
                    po_q  <= shift_once(po_q, dir_right_q, rot_q, sin_msb, sin_lsb);
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign po       = po_q;
    assign sout_msb = po_q[WIDTH-1];
    assign sout_lsb = po_q[0];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
